// File: rtl/pipe_ctrl.sv
// Hazard/exception controller for the 5-stage Y86-64 pipeline: per-cycle stall/bubble
// controls, run/drain/stopped sequencing and saturating performance counters.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    input  logic [3:0]       W_icode,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic [1:0]       cpu_state,
    output logic [2:0]       final_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [2:0] S_AOK    = 3'd1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_STOPPED = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] final_stat_reg;

    logic lu, ret, mis, mexc, wexc;

    // RNONE guard keeps instructions without a memory destination from stalling decode
    assign lu   = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != R_NONE)
                  && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign ret  = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign mis  = (E_icode == I_JXX) && !e_Cnd;
    assign mexc = (m_stat != S_AOK);
    assign wexc = (W_stat != S_AOK);

    always_comb begin
        F_stall  = lu || ret;
        D_stall  = lu;
        D_bubble = mis || (ret && !lu);
        E_bubble = mis || lu;
        M_bubble = mexc || wexc;
        W_stall  = wexc;
        set_cc   = (E_icode == I_OPQ) && !mexc && !wexc;
        if (!rst_n) begin
            // Fill the pipeline with bubbles while held in reset
            F_stall  = 1'b0;
            D_stall  = 1'b0;
            D_bubble = 1'b0;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            W_stall  = 1'b0;
            set_cc   = 1'b0;
        end else if (state_reg == ST_STOPPED) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            D_bubble = 1'b0;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            W_stall  = 1'b1;
            set_cc   = 1'b0;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN: begin
                if (wexc)      state_next = ST_STOPPED;
                else if (mexc) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (wexc) state_next = ST_STOPPED;
            end
            default: state_next = ST_STOPPED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_RUN;
            final_stat_reg <= S_AOK;
        end else begin
            state_reg <= state_next;
            if ((state_reg != ST_STOPPED) && (state_next == ST_STOPPED))
                final_stat_reg <= W_stat;
        end
    end

    assign cpu_state  = state_reg;
    assign final_stat = final_stat_reg;

    // Counter order: cycles, retired, load-use stalls, mispredicts
    logic [3:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [4];

    assign cnt_inc[0] = 1'b1;
    assign cnt_inc[1] = (W_stat == S_AOK) && (W_icode != I_NOP);
    assign cnt_inc[2] = lu;
    assign cnt_inc[3] = mis;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cnt_reg[gi] <= '0;
                else if ((state_reg != ST_STOPPED) && cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}}))
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
            end
        end
    endgenerate

    assign cyc_cnt      = cnt_reg[0];
    assign retired_cnt  = cnt_reg[1];
    assign lu_stall_cnt = cnt_reg[2];
    assign mispred_cnt  = cnt_reg[3];

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; a second CNT_W=4 instance covers saturation.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
    logic       e_Cnd;
    logic [2:0] m_stat, W_stat;

    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
    logic [1:0]  cpu_state;
    logic [2:0]  final_stat;
    logic [31:0] cyc_cnt, retired_cnt, lu_stall_cnt, mispred_cnt;

    logic        F_stall4, D_stall4, D_bubble4, E_bubble4, M_bubble4, W_stall4, set_cc4;
    logic [1:0]  cpu_state4;
    logic [2:0]  final_stat4;
    logic [3:0]  cyc_cnt4, retired_cnt4, lu_stall_cnt4, mispred_cnt4;

    // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
    logic [6:0] ctl;
    assign ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};

    int n_total = 0;
    int n_pass  = 0;
    int exp_cyc = 0;
    int exp_lu  = 0;
    int exp_mis = 0;
    int exp_ret = 0;
    bit exp_running = 1'b1;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
        .m_stat(m_stat), .W_stat(W_stat), .W_icode(W_icode),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc),
        .cpu_state(cpu_state), .final_stat(final_stat), .cyc_cnt(cyc_cnt),
        .retired_cnt(retired_cnt), .lu_stall_cnt(lu_stall_cnt), .mispred_cnt(mispred_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
        .m_stat(m_stat), .W_stat(W_stat), .W_icode(W_icode),
        .F_stall(F_stall4), .D_stall(D_stall4), .D_bubble(D_bubble4), .E_bubble(E_bubble4),
        .M_bubble(M_bubble4), .W_stall(W_stall4), .set_cc(set_cc4),
        .cpu_state(cpu_state4), .final_stat(final_stat4), .cyc_cnt(cyc_cnt4),
        .retired_cnt(retired_cnt4), .lu_stall_cnt(lu_stall_cnt4), .mispred_cnt(mispred_cnt4)
    );

    task automatic set_idle();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
        d_srcA  = 4'hF; d_srcB  = 4'hF; E_dstM  = 4'hF; e_Cnd   = 1'b1;
        m_stat  = 3'd1; W_stat  = 3'd1;
    endtask

    // One rising edge, sampled again on the following falling edge
    task automatic tick();
        @(posedge clk);
        if (exp_running) exp_cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        $display("reset: ctl=%b state=%0d stat=%0d cyc=%0d", ctl, cpu_state, final_stat, cyc_cnt);
        n_total++;
        if (ctl !== 7'b0001100) $display("FAIL reset_ctl: got %b want %b", ctl, 7'b0001100);
        else n_pass++;
        n_total++;
        if (cpu_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", cpu_state);
        else n_pass++;
        n_total++;
        if (final_stat !== 3'd1) $display("FAIL reset_final_stat: got %0d want 1", final_stat);
        else n_pass++;
        n_total++;
        if (cyc_cnt !== 32'd0 || retired_cnt !== 32'd0) $display("FAIL reset_counters: got cyc=%0d ret=%0d want 0/0", cyc_cnt, retired_cnt);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cyc = 0; exp_running = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 3; i++) tick();
        $display("idle: ctl=%b cyc=%0d", ctl, cyc_cnt);
        n_total++;
        if (ctl !== 7'b0000000) $display("FAIL idle_ctl: got %b want %b", ctl, 7'b0000000);
        else n_pass++;
        n_total++;
        if (cyc_cnt !== 32'(exp_cyc)) $display("FAIL idle_cyc: got %0d want %0d", cyc_cnt, exp_cyc);
        else n_pass++;
    endtask

    task automatic test_load_use();
        set_idle();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        #1;
        $display("load_use srcA: ctl=%b", ctl);
        n_total++;
        if (ctl !== 7'b1101000) $display("FAIL lu_srcA_ctl: got %b want %b", ctl, 7'b1101000);
        else n_pass++;
        tick(); exp_lu++;
        n_total++;
        if (lu_stall_cnt !== 32'(exp_lu)) $display("FAIL lu_cnt: got %0d want %0d", lu_stall_cnt, exp_lu);
        else n_pass++;
        d_srcA = 4'h2; d_srcB = 4'h3;
        #1;
        $display("load_use srcB: ctl=%b", ctl);
        n_total++;
        if (ctl !== 7'b1101000) $display("FAIL lu_srcB_ctl: got %b want %b", ctl, 7'b1101000);
        else n_pass++;
        tick(); exp_lu++;
        // popq into an unrelated register must not stall
        E_icode = 4'hB; d_srcB = 4'h4;
        #1;
        n_total++;
        if (ctl !== 7'b0000000) $display("FAIL lu_nomatch_ctl: got %b want %b", ctl, 7'b0000000);
        else n_pass++;
    endtask

    task automatic test_no_false_hazard();
        set_idle();
        E_icode = 4'h5; E_dstM = 4'hF; d_srcA = 4'hF;
        #1;
        $display("no_false_hazard: ctl=%b", ctl);
        n_total++;
        if (ctl !== 7'b0000000) $display("FAIL rnone_ctl: got %b want %b", ctl, 7'b0000000);
        else n_pass++;
        tick();
        n_total++;
        if (lu_stall_cnt !== 32'(exp_lu)) $display("FAIL rnone_cnt: got %0d want %0d", lu_stall_cnt, exp_lu);
        else n_pass++;
    endtask

    task automatic test_mispredict();
        set_idle();
        E_icode = 4'h7; e_Cnd = 1'b0; M_icode = 4'h9;
        #1;
        $display("mispredict+ret: ctl=%b", ctl);
        n_total++;
        if (ctl !== 7'b1011000) $display("FAIL mis_ctl: got %b want %b", ctl, 7'b1011000);
        else n_pass++;
        tick(); exp_mis++;
        n_total++;
        if (mispred_cnt !== 32'(exp_mis)) $display("FAIL mis_cnt: got %0d want %0d", mispred_cnt, exp_mis);
        else n_pass++;
        set_idle();
        E_icode = 4'h7; e_Cnd = 1'b1;
        #1;
        n_total++;
        if (ctl !== 7'b0000000) $display("FAIL taken_ctl: got %b want %b", ctl, 7'b0000000);
        else n_pass++;
        tick();
        n_total++;
        if (mispred_cnt !== 32'(exp_mis)) $display("FAIL taken_cnt: got %0d want %0d", mispred_cnt, exp_mis);
        else n_pass++;
    endtask

    task automatic test_ret();
        set_idle();
        D_icode = 4'h9;
        for (int i = 0; i < 3; i++) begin
            #1;
            $display("ret cycle %0d: ctl=%b", i, ctl);
            n_total++;
            if (ctl !== 7'b1010000) $display("FAIL ret_ctl_%0d: got %b want %b", i, ctl, 7'b1010000);
            else n_pass++;
            tick();
        end
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        #1;
        $display("ret+load_use: ctl=%b", ctl);
        n_total++;
        if (ctl !== 7'b1101000) $display("FAIL ret_lu_ctl: got %b want %b", ctl, 7'b1101000);
        else n_pass++;
        tick(); exp_lu++;
        n_total++;
        if (lu_stall_cnt !== 32'(exp_lu)) $display("FAIL ret_lu_cnt: got %0d want %0d", lu_stall_cnt, exp_lu);
        else n_pass++;
    endtask

    task automatic test_cc_retire();
        set_idle();
        E_icode = 4'h6; W_icode = 4'h6;
        #1;
        $display("opq set_cc: ctl=%b", ctl);
        n_total++;
        if (ctl !== 7'b0000001) $display("FAIL setcc_ctl: got %b want %b", ctl, 7'b0000001);
        else n_pass++;
        tick(); exp_ret++;
        tick(); exp_ret++;
        W_icode = 4'h1;
        tick();
        $display("retire: retired=%0d", retired_cnt);
        n_total++;
        if (retired_cnt !== 32'(exp_ret)) $display("FAIL retired_cnt: got %0d want %0d", retired_cnt, exp_ret);
        else n_pass++;
    endtask

    task automatic test_halt();
        set_idle();
        E_icode = 4'h6; m_stat = 3'd2;
        #1;
        $display("halt in M: ctl=%b", ctl);
        n_total++;
        if (ctl !== 7'b0000100) $display("FAIL mexc_ctl: got %b want %b", ctl, 7'b0000100);
        else n_pass++;
        tick();
        n_total++;
        if (cpu_state !== 2'd1) $display("FAIL drain_state: got %0d want 1", cpu_state);
        else n_pass++;
        set_idle();
        W_stat = 3'd2; W_icode = 4'h0;
        #1;
        $display("halt in W: ctl=%b", ctl);
        n_total++;
        if (ctl !== 7'b0000110) $display("FAIL wexc_ctl: got %b want %b", ctl, 7'b0000110);
        else n_pass++;
        tick(); exp_running = 1'b0;
        $display("stopped: state=%0d stat=%0d", cpu_state, final_stat);
        n_total++;
        if (cpu_state !== 2'd2 || final_stat !== 3'd2) $display("FAIL stop_state: got state=%0d stat=%0d want 2/2", cpu_state, final_stat);
        else n_pass++;
        // Hazard stimulus while stopped must neither change outputs nor count
        set_idle();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; W_icode = 4'h6;
        #1;
        n_total++;
        if (ctl !== 7'b1101110) $display("FAIL stopped_ctl: got %b want %b", ctl, 7'b1101110);
        else n_pass++;
        for (int i = 0; i < 3; i++) tick();
        $display("frozen: cyc=%0d lu=%0d ret=%0d", cyc_cnt, lu_stall_cnt, retired_cnt);
        n_total++;
        if (cyc_cnt !== 32'(exp_cyc) || lu_stall_cnt !== 32'(exp_lu) || retired_cnt !== 32'(exp_ret))
            $display("FAIL frozen_cnt: got cyc=%0d lu=%0d ret=%0d want %0d/%0d/%0d", cyc_cnt, lu_stall_cnt, retired_cnt, exp_cyc, exp_lu, exp_ret);
        else n_pass++;
        n_total++;
        if (cpu_state !== 2'd2 || final_stat !== 3'd2) $display("FAIL sticky_state: got state=%0d stat=%0d want 2/2", cpu_state, final_stat);
        else n_pass++;
    endtask

    task automatic test_reset_from_stopped();
        set_idle();
        rst_n = 1'b0;
        #1;
        $display("reset from stopped: state=%0d cyc=%0d ctl=%b", cpu_state, cyc_cnt, ctl);
        n_total++;
        if (cpu_state !== 2'd0 || cyc_cnt !== 32'd0 || mispred_cnt !== 32'd0) $display("FAIL async_reset: got state=%0d cyc=%0d mis=%0d want 0/0/0", cpu_state, cyc_cnt, mispred_cnt);
        else n_pass++;
        n_total++;
        if (ctl !== 7'b0001100 || final_stat !== 3'd1) $display("FAIL async_reset_out: got ctl=%b stat=%0d want %b/1", ctl, final_stat, 7'b0001100);
        else n_pass++;
        #1;
        rst_n = 1'b1;
        exp_cyc = 0; exp_lu = 0; exp_mis = 0; exp_ret = 0; exp_running = 1'b1;
        #1;
        n_total++;
        if (ctl !== 7'b0000000) $display("FAIL post_reset_ctl: got %b want %b", ctl, 7'b0000000);
        else n_pass++;
    endtask

    task automatic test_direct_stop();
        set_idle();
        W_stat = 3'd3;
        #1;
        n_total++;
        if (ctl !== 7'b0000110) $display("FAIL adr_ctl: got %b want %b", ctl, 7'b0000110);
        else n_pass++;
        tick(); exp_running = 1'b0;
        $display("direct stop: state=%0d stat=%0d cyc=%0d", cpu_state, final_stat, cyc_cnt);
        n_total++;
        if (cpu_state !== 2'd2 || final_stat !== 3'd3) $display("FAIL adr_stop: got state=%0d stat=%0d want 2/3", cpu_state, final_stat);
        else n_pass++;
        n_total++;
        if (cyc_cnt !== 32'(exp_cyc)) $display("FAIL adr_cyc: got %0d want %0d", cyc_cnt, exp_cyc);
        else n_pass++;
    endtask

    task automatic test_saturation();
        set_idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_cyc = 0; exp_running = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        $display("saturation: cyc4=%0d cyc32=%0d", cyc_cnt4, cyc_cnt);
        n_total++;
        if (cyc_cnt4 !== 4'd15) $display("FAIL sat_cyc4: got %0d want 15", cyc_cnt4);
        else n_pass++;
        n_total++;
        if (cyc_cnt !== 32'(exp_cyc)) $display("FAIL sat_cyc32: got %0d want %0d", cyc_cnt, exp_cyc);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        test_reset();
        test_idle();
        test_load_use();
        test_no_false_hazard();
        test_mispredict();
        test_ret();
        test_cc_retire();
        test_halt();
        test_reset_from_stopped();
        test_direct_stop();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
